// File: rtl/riscv_debug_pkg.sv
// Shared types and helpers for the toggle-word UART debug output.
// Contents: formatter / serialiser state enums, ASCII CR/LF codes and a
// nibble-to-uppercase-hex-ASCII converter.
package riscv_debug_pkg;

  typedef enum logic [1:0] {
    FMT_IDLE,
    FMT_LOAD,
    FMT_WAIT
  } fmt_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first, line idles high.
// Ports:
//   clk, resetn  - clock, async active-low reset
//   start        - accepted only in IDLE; latches data and begins a frame
//   data[7:0]    - byte to send
//   tx           - serial line (registered)
//   done         - 1-cycle pulse during the last STOP-bit cycle
//   idle         - high when no frame is in progress
module uart_tx_byte
  import riscv_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       idle
);

  localparam int            CW      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  ser_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          last_cnt;

  assign last_cnt = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    if (state_q != SER_IDLE) cnt_d = last_cnt ? '0 : cnt_q + CNT_ONE;
    case (state_q)
      SER_IDLE: begin
        if (start) begin
          state_d = SER_START;
          cnt_d   = '0;
          bit_d   = '0;
          shreg_d = data;
          tx_d    = 1'b0;
        end
      end
      SER_START: begin
        if (last_cnt) begin
          state_d = SER_DATA;
          tx_d    = shreg_q[0];
        end
      end
      SER_DATA: begin
        if (last_cnt) begin
          if (bit_q == 3'd7) begin
            state_d = SER_STOP;
            tx_d    = 1'b1;
          end else begin
            // shift so the next bit is always at [0]; drive it one step early
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
      SER_STOP: begin
        if (last_cnt) state_d = SER_IDLE;
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign done = (state_q == SER_STOP) && last_cnt;
  assign idle = (state_q == SER_IDLE);

endmodule

// File: rtl/toggle_uart_tx.sv
// Reports every change of the core's toggle word over UART as
// "XXXXXXXX\r\n" (uppercase hex, MSB nibble first).
// Ports:
//   clk, resetn         - clock, async active-low reset
//   toggle_value[31:0]  - sampled every clk; changes are queued
//   tx                  - UART 8N1 line
//   tx_Data[7:0]        - last character handed to the serialiser
//   tx_DataValid        - 1-cycle strobe when tx_Data is loaded
//   busy                - FIFO non-empty, frame or byte in progress
//   overflow            - sticky: a change was dropped on a full FIFO
module toggle_uart_tx
  import riscv_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] toggle_value,
  output logic        tx,
  output logic [7:0]  tx_Data,
  output logic        tx_DataValid,
  output logic        busy,
  output logic        overflow
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // change detect + FIFO
  logic [31:0]                  prev_q, prev_d;
  logic [FIFO_DEPTH-1:0][31:0]  mem_q, mem_d;
  logic [AW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                         overflow_q, overflow_d;
  logic                         change, push, pop, empty, full;
  logic [31:0]                  head;

  // formatter
  fmt_state_e  fmt_q, fmt_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_dv_q, tx_dv_d;
  logic [7:0]  cur_char;
  logic        ser_done, ser_idle;

  // extra wrap bit distinguishes full from empty
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head   = mem_q[rd_ptr_q[AW-1:0]];
  assign change = (toggle_value != prev_q);
  assign pop    = (fmt_q == FMT_IDLE) && !empty;
  // a pop in the same edge frees the slot the push needs
  assign push   = change && (!full || pop);

  always_comb begin
    prev_d     = change ? toggle_value : prev_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (change && !push);
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = toggle_value;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // word_q is shifted left per character so the current nibble is always [31:28]
  always_comb begin
    case (idx_q)
      4'd8:    cur_char = ASCII_CR;
      4'd9:    cur_char = ASCII_LF;
      default: cur_char = nibble_to_ascii(word_q[31:28]);
    endcase
  end

  always_comb begin
    fmt_d     = fmt_q;
    word_d    = word_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    tx_dv_d   = 1'b0;
    case (fmt_q)
      FMT_IDLE: begin
        if (!empty) begin
          word_d = head;
          idx_d  = '0;
          fmt_d  = FMT_LOAD;
        end
      end
      FMT_LOAD: begin
        tx_dv_d   = 1'b1;
        tx_data_d = cur_char;
        fmt_d     = FMT_WAIT;
      end
      FMT_WAIT: begin
        if (ser_done) begin
          if (idx_q == 4'd9) begin
            fmt_d = FMT_IDLE;
          end else begin
            idx_d  = idx_q + 4'd1;
            word_d = {word_q[27:0], 4'h0};
            fmt_d  = FMT_LOAD;
          end
        end
      end
      default: fmt_d = FMT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q     <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      fmt_q      <= FMT_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_dv_q    <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      fmt_q      <= fmt_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_dv_q    <= tx_dv_d;
    end
  end

  // the registered strobe doubles as the serialiser start
  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk   (clk),
    .resetn(resetn),
    .start (tx_dv_q),
    .data  (tx_data_q),
    .tx    (tx),
    .done  (ser_done),
    .idle  (ser_idle)
  );

  assign tx_Data      = tx_data_q;
  assign tx_DataValid = tx_dv_q;
  assign overflow     = overflow_q;
  assign busy         = !empty || (fmt_q != FMT_IDLE) || !ser_idle;

endmodule

// File: tb/tb_toggle_uart_tx.sv
// Bench for toggle_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Expected characters are queued when a reportable change is driven; the
// strobe monitor checks tx_Data and the line decoder checks the 8N1 stream.
module tb_toggle_uart_tx;
  localparam int CPB     = 4;
  localparam int DEPTH   = 4;
  localparam int CHAR_T  = 10 * CPB + 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] toggle_value = '0;
  logic        tx, tx_DataValid, busy, overflow;
  logic [7:0]  tx_Data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobes = 0;
  logic [7:0] exp_data_q[$];
  logic [7:0] exp_line_q[$];

  toggle_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .toggle_value(toggle_value),
    .tx          (tx),
    .tx_Data     (tx_Data),
    .tx_DataValid(tx_DataValid),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_word(input logic [31:0] w);
    logic [3:0] n;
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      n = w[31-4*i -: 4];
      e = (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h41 + {4'd0, n} - 8'd10);
      exp_data_q.push_back(e);
      exp_line_q.push_back(e);
    end
    exp_data_q.push_back(8'h0D); exp_line_q.push_back(8'h0D);
    exp_data_q.push_back(8'h0A); exp_line_q.push_back(8'h0A);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick(1);
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
    tick(2);
    chk("data_q_drained", exp_data_q.size(), 32'd0);
    chk("line_q_drained", exp_line_q.size(), 32'd0);
  endtask

  // tx_Data scoreboard
  initial forever begin
    @(negedge clk);
    if (resetn && tx_DataValid === 1'b1) begin
      strobes++;
      if (exp_data_q.size() == 0) chk("tx_Data_unexpected", {24'd0, tx_Data}, 32'h100);
      else chk("tx_Data", {24'd0, tx_Data}, {24'd0, exp_data_q.pop_front()});
    end
  end

  // UART line decoder with char spacing / frame span timing
  initial begin : decoder
    logic       act, txp;
    logic [7:0] b;
    int         cnt, pos, fall_c, frame_c, i;
    act = 1'b0; txp = 1'b1; b = '0;
    cnt = 0; pos = 0; fall_c = 0; frame_c = 0; i = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        act = 1'b0;
        pos = 0;
      end else if (!act) begin
        if (txp === 1'b1 && tx === 1'b0) begin
          act = 1'b1;
          cnt = 0;
          if (pos != 0) chk("char_spacing", cyc - fall_c, CHAR_T);
          else frame_c = cyc;
          if (pos == 9) chk("frame_span", cyc - frame_c, 9 * CHAR_T);
          fall_c = cyc;
        end
      end else begin
        cnt++;
        if ((cnt % CPB) == CPB / 2) begin
          i = cnt / CPB;
          if (i == 0) chk("start_bit", {31'd0, tx}, 32'd0);
          else if (i <= 8) b[i-1] = tx;
          else begin
            chk("stop_bit", {31'd0, tx}, 32'd1);
            if (exp_line_q.size() == 0) chk("line_unexpected", {24'd0, b}, 32'h100);
            else chk("line_byte", {24'd0, b}, {24'd0, exp_line_q.pop_front()});
            act = 1'b0;
            pos = (pos == 9) ? 0 : pos + 1;
          end
        end
      end
      txp = tx;
    end
  end

  initial begin
    int bad;
    logic [31:0] v [6];
    v[0] = 32'h89ABCDEF; v[1] = 32'h00000001; v[2] = 32'hDEADBEEF;
    v[3] = 32'h0F0F0F0F; v[4] = 32'h7E57C0DE; v[5] = 32'hA5A5A5A5;

    // reset values
    resetn = 1'b0;
    toggle_value = '0;
    tick(3);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dv", {31'd0, tx_DataValid}, 32'd0);
    chk("rst_data", {24'd0, tx_Data}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    resetn = 1'b1;

    // constant zero: nothing reported
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 32'd0);
    chk("idle_no_strobe", strobes, 32'd0);

    // single-cycle pulse -> two frames, latency checks
    toggle_value = 32'h1234ABCD;
    expect_word(32'h1234ABCD);
    tick(1);                          // after change edge N
    chk("busy_after_push", {31'd0, busy}, 32'd1);
    toggle_value = 32'h0;
    expect_word(32'h0);
    tick(1);                          // after N+1 (pop)
    chk("dv_at_pop", {31'd0, tx_DataValid}, 32'd0);
    chk("tx_at_pop", {31'd0, tx}, 32'd1);
    tick(1);                          // after N+2
    chk("dv_first", {31'd0, tx_DataValid}, 32'd1);
    chk("data_first", {24'd0, tx_Data}, 32'h31);
    chk("tx_before_start", {31'd0, tx}, 32'd1);
    tick(1);                          // after N+3
    chk("tx_start_edge", {31'd0, tx}, 32'd0);
    chk("dv_one_cycle", {31'd0, tx_DataValid}, 32'd0);
    wait_idle(3000);

    // FIFO full exactly when the formatter pops: change must be accepted
    toggle_value = v[0];
    expect_word(v[0]);
    for (int k = 1; k < 5; k++) begin
      tick(1);
      toggle_value = v[k];
      expect_word(v[k]);
    end
    tick(418);                        // just before the pop edge N+422
    toggle_value = v[5];
    expect_word(v[5]);
    tick(1);
    chk("ovf_pop_same_edge", {31'd0, overflow}, 32'd0);
    wait_idle(6 * 10 * CHAR_T + 200);
    chk("ovf_after_6_frames", {31'd0, overflow}, 32'd0);

    // burst of 6: value 6 dropped
    toggle_value = 32'h11111111;
    expect_word(32'h11111111);
    for (int k = 1; k < 6; k++) begin
      tick(1);
      if (k == 5) chk("ovf_before_drop", {31'd0, overflow}, 32'd0);
      toggle_value = 32'h11111111 * (k + 1);
      if (k < 5) expect_word(32'h11111111 * (k + 1));
    end
    tick(1);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    wait_idle(5 * 10 * CHAR_T + 200);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // reset in the middle of character 3's data bits
    toggle_value = 32'hCAFEF00D;
    expect_word(32'hCAFEF00D);
    tick(140);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_dv", {31'd0, tx_DataValid}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    exp_data_q.delete();
    exp_line_q.delete();
    tick(3);
    resetn = 1'b1;
    expect_word(32'hCAFEF00D);
    tick(1);
    chk("rereport_busy", {31'd0, busy}, 32'd1);
    wait_idle(10 * CHAR_T + 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
